fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences the fetch stage's PC-update controls: pc_enb, jump_sel, pop_l_h and flush.
- Arbitrates between sequential fetch, decode-stage jumps, two-word return-address pops (RET/RTI), interrupt entry and halt.
- Sits beside the fetch stage; takes decode/execute/writeback events and the hazard unit's stall, and drives fetch plus the pipeline's push request.

Parameters:
- RET_WAIT_MAX, 15: max cycles to wait for each popped word before ctrl_err is raised.
- INT_EN_RST, 1: interrupt-enable value after reset.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall_hz  in  1  hazard-unit load-use stall
- jmp_D  in  1  taken jump/call resolved in decode (target is Rdst_D)
- branch_E  in  1  taken branch in execute; fetch applies the redirect itself
- ret_D  in  1  RET decoded
- rti_D  in  1  RTI decoded
- hlt_D  in  1  HLT decoded
- int_req  in  1  external interrupt, level
- wb_pop  in  1  writeback carries a popped PC word this cycle
- pc_enb  out  1  PC register enable
- jump_sel  out  2  00 PC+1, 01 Rdst_D, 10 ISR, 11 popped return address
- pop_l_h  out  2  [1] = pop-register write enable, [0] = 1 high word / 0 low word
- flush  out  1  replace the fetched instruction with NOP
- stall_D  out  1  hold the IF/ID register
- push_pc  out  2  [1] = push request, [0] = 1 high word / 0 low word (interrupt entry)
- int_ack  out  1  one-cycle pulse when the ISR vector is loaded
- flag_restore  out  1  one-cycle pulse when an RTI completes
- ctrl_err  out  1  sticky watchdog error

Behaviour:
- Reset values (async, asserted immediately): state RUN, pc_enb=1, jump_sel=00, pop_l_h=00, flush=0, stall_D=0, push_pc=00, int_ack=0, flag_restore=0, ctrl_err=0, int_en=INT_EN_RST, int_pend=0, counter=0.
- int_pend is set on any cycle with int_req=1 && int_en. It clears when INT_VEC is left.
- States and transitions:
  - RUN:
    - Default outputs pc_enb=!stall_hz, jump_sel=00.
    - Priority: branch_E > ret_D/rti_D > jmp_D > hlt_D > int_pend.
    - branch_E: stay in RUN, pc_enb=1. Fetch performs the redirect and NOP. All decode-stage events that cycle are ignored (they are squashed).
    - jmp_D: jump_sel=01, pc_enb=1, flush=1 for one cycle.
    - ret_D or rti_D: latch is_rti; go to RET_HI. pc_enb=0 and flush=1 from this cycle onward.
    - hlt_D: go to HALT.
    - int_pend and !stall_hz: go to INT_PUSH_HI, with pc_enb=0 and flush=1.
  - RET_HI: pc_enb=0, flush=1, stall_D=1. When wb_pop=1: pop_l_h=11 that cycle, then go to RET_LO.
  - RET_LO: same holds. When wb_pop=1: pop_l_h=10, then go to RET_LOAD.
  - RET_LOAD: jump_sel=11, pc_enb=1, flush=1. If is_rti: flag_restore=1 and int_en=1. Then go to RUN.
  - INT_PUSH_HI: push_pc=11, pc_enb=0, flush=1, stall_D=1; go to INT_PUSH_LO.
  - INT_PUSH_LO: push_pc=10, same holds; go to INT_VEC.
  - INT_VEC: jump_sel=10, pc_enb=1, flush=1, int_ack=1, int_en=0, int_pend cleared; go to RUN.
  - HALT: pc_enb=0, flush=1. Leaves only via int_pend, going to INT_PUSH_HI; the return address is the HLT's PC+1.
- Watchdog:
  - counter increments each cycle in RET_HI/RET_LO while wb_pop=0, and resets on wb_pop.
  - When counter reaches RET_WAIT_MAX: ctrl_err=1 (sticky until rst) and go to RUN with jump_sel=00.
- Boundaries:
  - Nested interrupt: blocked, since int_en=0 until RTI completes. An interrupt arriving during the RET sequence stays pending and is taken from RUN afterwards.
  - wb_pop in a state other than RET_HI/RET_LO is ignored.
  - stall_hz is ignored outside RUN.
  - rst asserted mid-sequence aborts it immediately; no partial pop or push completes.
  - Every state exit is registered. All outputs are Moore-style per state except the RUN redirects and the pop_l_h strobe, which are combinational on inputs (same-cycle).
- Latency: RET costs 2 + pop wait + 1 cycles. Interrupt entry costs 3 cycles.

Decomposition:
- Package fetch_ctrl_pkg:
  - state enum (RUN, RET_HI, RET_LO, RET_LOAD, INT_PUSH_HI, INT_PUSH_LO, INT_VEC, HALT)
  - JUMP_SEL constants (SEL_PC1, SEL_RDST_D, SEL_ISR, SEL_RET)
  - POP/PUSH encodings
- Sub-module: ret_watchdog. A saturating counter with clear/inc/limit and a sticky error output.

Test Plan:
1. rst pulsed mid-cycle during RET_LO -> outputs return to reset values immediately; state RUN; next pop_l_h=00.
2. ret_D=1, then wb_pop at +2 and +4 cycles -> pop_l_h=11 then 10 on those cycles; next cycle jump_sel=11, pc_enb=1; pc_enb=0 in between.
3. int_req=1 in RUN with no stall -> push_pc=11, then 10; then jump_sel=10 with int_ack=1 three cycles after acceptance; a second int_req is not acked until rti completes with flag_restore=1.
4. branch_E=1 and jmp_D=1 in the same cycle -> jump_sel=00, flush=0 from ctrl, no FSM change.
5. ret_D with no wb_pop for 15 cycles -> ctrl_err=1 at cycle 15 and stays high; state RUN.
6. hlt_D -> pc_enb=0 indefinitely; then int_req -> push sequence, ISR vector, int_ack=1.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and encodings for the fetch-stage PC-update controller.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN,
        RET_HI,
        RET_LO,
        RET_LOAD,
        INT_PUSH_HI,
        INT_PUSH_LO,
        INT_VEC,
        HALT
    } state_t;

    // PC source select for the fetch-stage mux
    localparam logic [1:0] SEL_PC1    = 2'b00;
    localparam logic [1:0] SEL_RDST_D = 2'b01;
    localparam logic [1:0] SEL_ISR    = 2'b10;
    localparam logic [1:0] SEL_RET    = 2'b11;

    // {write enable, high word}
    localparam logic [1:0] POP_NONE  = 2'b00;
    localparam logic [1:0] POP_HI    = 2'b11;
    localparam logic [1:0] POP_LO    = 2'b10;

    // {request, high word}
    localparam logic [1:0] PUSH_NONE = 2'b00;
    localparam logic [1:0] PUSH_HI   = 2'b11;
    localparam logic [1:0] PUSH_LO   = 2'b10;

    // True while the controller is waiting for a popped return-address word
    function automatic logic in_ret_wait(input state_t s);
        return (s == RET_HI) || (s == RET_LO);
    endfunction

endpackage

// File: rtl/fetch_ctrl_ret_watchdog.sv
// Wait-cycle counter for return-address pops with a sticky timeout error.
module ret_watchdog #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic limit,
    output logic err
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt;

    // limit fires on the increment that would make the count reach LIMIT
    assign limit = inc && (cnt == LAST);

    // Counter saturates at LAST; clear has priority over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !limit) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Error stays set until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (limit) begin
            err <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC-update sequencer: jumps, RET/RTI pops, interrupt entry, halt.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned RET_WAIT_MAX = 15,
    parameter bit          INT_EN_RST   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall_hz,
    input  logic       jmp_D,
    input  logic       branch_E,
    input  logic       ret_D,
    input  logic       rti_D,
    input  logic       hlt_D,
    input  logic       int_req,
    input  logic       wb_pop,
    output logic       pc_enb,
    output logic [1:0] jump_sel,
    output logic [1:0] pop_l_h,
    output logic       flush,
    output logic       stall_D,
    output logic [1:0] push_pc,
    output logic       int_ack,
    output logic       flag_restore,
    output logic       ctrl_err
);

    state_t state, state_n;
    logic   is_rti;
    logic   int_en;
    logic   int_pend;
    logic   take_ret;
    logic   wd_inc;
    logic   wd_limit;

    assign wd_inc = in_ret_wait(state) && !wb_pop;

    ret_watchdog #(
        .LIMIT (RET_WAIT_MAX)
    ) u_wd (
        .clk   (clk),
        .rst   (rst),
        .clr   (!wd_inc),
        .inc   (wd_inc),
        .limit (wd_limit),
        .err   (ctrl_err)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    // Remember whether the pending return sequence came from RTI
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_rti <= 1'b0;
        end else if (take_ret) begin
            is_rti <= rti_D;
        end
    end

    // Interrupt enable: cleared on vector load, restored when RTI completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_en <= INT_EN_RST;
        end else if (state == INT_VEC) begin
            int_en <= 1'b0;
        end else if ((state == RET_LOAD) && is_rti) begin
            int_en <= 1'b1;
        end
    end

    // Pending interrupt: clearing on INT_VEC exit wins over a new request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_pend <= 1'b0;
        end else if (state == INT_VEC) begin
            int_pend <= 1'b0;
        end else if (int_req && int_en) begin
            int_pend <= 1'b1;
        end
    end

    // Next state and outputs; RUN redirects and pop strobes follow inputs
    always_comb begin
        state_n      = state;
        pc_enb       = 1'b0;
        jump_sel     = SEL_PC1;
        pop_l_h      = POP_NONE;
        flush        = 1'b0;
        stall_D      = 1'b0;
        push_pc      = PUSH_NONE;
        int_ack      = 1'b0;
        flag_restore = 1'b0;
        take_ret     = 1'b0;

        case (state)
            RUN: begin
                pc_enb = !stall_hz;
                if (branch_E) begin
                    pc_enb = 1'b1;
                end else if (ret_D || rti_D) begin
                    take_ret = 1'b1;
                    pc_enb   = 1'b0;
                    flush    = 1'b1;
                    state_n  = RET_HI;
                end else if (jmp_D) begin
                    jump_sel = SEL_RDST_D;
                    pc_enb   = 1'b1;
                    flush    = 1'b1;
                end else if (hlt_D) begin
                    // PC is frozen here so the saved return address is HLT+1
                    pc_enb  = 1'b0;
                    flush   = 1'b1;
                    state_n = HALT;
                end else if (int_pend && !stall_hz) begin
                    pc_enb  = 1'b0;
                    flush   = 1'b1;
                    state_n = INT_PUSH_HI;
                end
            end
            RET_HI: begin
                flush   = 1'b1;
                stall_D = 1'b1;
                if (wb_pop) begin
                    pop_l_h = POP_HI;
                    state_n = RET_LO;
                end else if (wd_limit) begin
                    state_n = RUN;
                end
            end
            RET_LO: begin
                flush   = 1'b1;
                stall_D = 1'b1;
                if (wb_pop) begin
                    pop_l_h = POP_LO;
                    state_n = RET_LOAD;
                end else if (wd_limit) begin
                    state_n = RUN;
                end
            end
            RET_LOAD: begin
                jump_sel     = SEL_RET;
                pc_enb       = 1'b1;
                flush        = 1'b1;
                flag_restore = is_rti;
                state_n      = RUN;
            end
            INT_PUSH_HI: begin
                push_pc = PUSH_HI;
                flush   = 1'b1;
                stall_D = 1'b1;
                state_n = INT_PUSH_LO;
            end
            INT_PUSH_LO: begin
                push_pc = PUSH_LO;
                flush   = 1'b1;
                stall_D = 1'b1;
                state_n = INT_VEC;
            end
            INT_VEC: begin
                jump_sel = SEL_ISR;
                pc_enb   = 1'b1;
                flush    = 1'b1;
                int_ack  = 1'b1;
                state_n  = RUN;
            end
            HALT: begin
                flush = 1'b1;
                if (int_pend) begin
                    state_n = INT_PUSH_HI;
                end
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with randomized timing.
module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall_hz, jmp_D, branch_E, ret_D, rti_D, hlt_D, int_req, wb_pop;
    logic       pc_enb, flush, stall_D, int_ack, flag_restore, ctrl_err;
    logic [1:0] jump_sel, pop_l_h, push_pc;

    int tests = 0;
    int fails = 0;

    // Reference-model state: interrupt enable and sticky error
    logic m_int_en;
    logic m_err;

    localparam logic [7:0] I_STALL = 8'h01;
    localparam logic [7:0] I_JMP   = 8'h02;
    localparam logic [7:0] I_BR    = 8'h04;
    localparam logic [7:0] I_RET   = 8'h08;
    localparam logic [7:0] I_RTI   = 8'h10;
    localparam logic [7:0] I_HLT   = 8'h20;
    localparam logic [7:0] I_INT   = 8'h40;
    localparam logic [7:0] I_POP   = 8'h80;

    logic [11:0] obs;
    assign obs = {pc_enb, jump_sel, pop_l_h, flush, stall_D, push_pc,
                  int_ack, flag_restore, ctrl_err};

    fetch_ctrl #(
        .RET_WAIT_MAX (15),
        .INT_EN_RST   (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_hz     (stall_hz),
        .jmp_D        (jmp_D),
        .branch_E     (branch_E),
        .ret_D        (ret_D),
        .rti_D        (rti_D),
        .hlt_D        (hlt_D),
        .int_req      (int_req),
        .wb_pop       (wb_pop),
        .pc_enb       (pc_enb),
        .jump_sel     (jump_sel),
        .pop_l_h      (pop_l_h),
        .flush        (flush),
        .stall_D      (stall_D),
        .push_pc      (push_pc),
        .int_ack      (int_ack),
        .flag_restore (flag_restore),
        .ctrl_err     (ctrl_err)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ev(input logic pc, input logic [1:0] js,
                                       input logic [1:0] pop, input logic fl,
                                       input logic sd, input logic [1:0] push,
                                       input logic ack, input logic fr);
        return {pc, js, pop, fl, sd, push, ack, fr, m_err};
    endfunction

    // Expected RUN-state response without pending interrupt
    function automatic logic [11:0] run_exp(input logic [7:0] in);
        if (in[2])      return ev(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        else if (in[1]) return ev(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        else            return ev(!in[0], 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endfunction

    function automatic logic [11:0] hold_exp(input logic [1:0] pop);
        return ev(1'b0, 2'b00, pop, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    endfunction

    function automatic logic [11:0] freeze_exp();
        return ev(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    endfunction

    task automatic check(input string tag, input logic [11:0] o, input logic [11:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b (pc js pop fl sd push ack fr err)",
                   tag, o, e);
        end
    endtask

    task automatic drive(input logic [7:0] in);
        {wb_pop, int_req, hlt_D, rti_D, ret_D, branch_E, jmp_D, stall_hz} = in;
    endtask

    // Drive at posedge+1, check at the following negedge, advance to next posedge+1
    task automatic tick(input logic [7:0] in, input logic [11:0] e, input string tag);
        drive(in);
        #4;
        check(tag, obs, e);
        @(posedge clk);
        #1;
    endtask

    task automatic tick_nc(input logic [7:0] in);
        drive(in);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rnd_noise();
        logic [7:0] v;
        v = 8'h00;
        if ($urandom_range(0, 1) == 1) v = v | I_STALL;
        if ($urandom_range(0, 1) == 1) v = v | I_JMP;
        return v;
    endfunction

    // int_mode: 0 no interrupt, 1 int_req held throughout, 2 int_req pulsed on first pop
    task automatic do_ret(input logic rti, input int unsigned d1, input int unsigned d2,
                          input int unsigned int_mode);
        logic [7:0] hold_int;
        hold_int = (int_mode == 1) ? I_INT : 8'h00;
        tick((rti ? I_RTI : I_RET) | hold_int, freeze_exp(), "ret_accept");
        for (int unsigned i = 0; i < d1; i++)
            tick(rnd_noise() | hold_int, hold_exp(2'b00), "ret_hi_wait");
        tick(I_POP | hold_int | ((int_mode == 2) ? I_INT : 8'h00), hold_exp(2'b11), "pop_hi");
        for (int unsigned i = 0; i < d2; i++)
            tick(rnd_noise() | hold_int, hold_exp(2'b00), "ret_lo_wait");
        tick(I_POP | hold_int, hold_exp(2'b10), "pop_lo");
        tick(hold_int, ev(1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, rti), "ret_load");
        if (rti) m_int_en = 1'b1;
    endtask

    task automatic int_tail();
        tick(8'h00, ev(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0), "push_hi");
        tick(8'h00, ev(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0), "push_lo");
        tick(8'h00, ev(1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0), "int_vec");
        m_int_en = 1'b0;
    endtask

    initial begin
        logic [7:0] in;
        m_err    = 1'b0;
        m_int_en = 1'b1;
        drive(8'h00);
        rst = 1'b1;
        #2;
        check("reset_values", obs, ev(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(8'h00, run_exp(8'h00), "idle_after_reset");

        // Random RUN traffic; decode events alongside branch_E are squashed
        for (int i = 0; i < 40; i++) begin
            in = 8'h00;
            if ($urandom_range(0, 2) == 0) in = in | I_STALL;
            if ($urandom_range(0, 2) == 0) in = in | I_JMP;
            if ($urandom_range(0, 3) == 0) in = in | I_POP;
            if ($urandom_range(0, 3) == 0) begin
                in = in | I_BR;
                case ($urandom_range(0, 3))
                    0: in = in | I_RET;
                    1: in = in | I_RTI;
                    2: in = in | I_HLT;
                    default: ;
                endcase
            end
            tick(in, run_exp(in), "run_random");
        end

        tick(I_BR | I_JMP, run_exp(I_BR), "branch_over_jmp");
        tick(8'h00, run_exp(8'h00), "branch_no_fsm_change");
        tick(I_BR | I_RET, run_exp(I_BR), "branch_squash_ret");
        tick(8'h00, run_exp(8'h00), "ret_squashed");

        // RET sequences: minimal-ish, near-timeout, random waits
        do_ret(1'b0, 1, 1, 0);
        tick(8'h00, run_exp(8'h00), "after_ret");
        do_ret(1'b0, 14, 14, 0);
        repeat (3) do_ret(1'b0, $urandom_range(0, 6), $urandom_range(0, 6), 0);

        // Interrupt entry from RUN
        tick(I_INT, run_exp(8'h00), "int_req_seen");
        tick(8'h00, freeze_exp(), "int_accept");
        int_tail();

        // Nested interrupt blocked until RTI completes
        repeat (5) tick(I_INT, run_exp(8'h00), "nested_int_blocked");
        do_ret(1'b1, 2, 1, 1);
        tick(I_INT, run_exp(8'h00), "int_after_rti");
        tick(8'h00, freeze_exp(), "int_accept2");
        int_tail();
        do_ret(1'b1, $urandom_range(0, 4), $urandom_range(0, 4), 0);

        // Interrupt during plain RET stays pending and is taken in RUN
        do_ret(1'b0, 1, 1, 2);
        tick(8'h00, freeze_exp(), "pending_int_taken");
        int_tail();
        do_ret(1'b1, 0, 0, 0);

        // HALT holds until an interrupt arrives
        tick_nc(I_HLT);
        repeat (6) tick(rnd_noise() | (($urandom_range(0, 1) == 1) ? I_POP : 8'h00),
                        freeze_exp(), "halt_hold");
        tick(I_INT, freeze_exp(), "halt_int_req");
        tick(8'h00, freeze_exp(), "halt_int_pend");
        int_tail();
        do_ret(1'b1, 1, 0, 0);

        // Watchdog: 15 silent cycles in RET_HI raise the sticky error
        tick(I_RET, freeze_exp(), "wd_ret");
        for (int i = 0; i < 15; i++)
            tick(rnd_noise(), hold_exp(2'b00), "wd_wait");
        m_err = 1'b1;
        tick(8'h00, run_exp(8'h00), "wd_err_run");
        for (int i = 0; i < 3; i++) begin
            in = rnd_noise();
            tick(in, run_exp(in), "wd_err_sticky");
        end

        // Asynchronous reset in RET_LO
        tick(I_RET, freeze_exp(), "rst_ret");
        tick(I_POP, hold_exp(2'b11), "rst_pop_hi");
        #1;
        rst = 1'b1;
        m_err = 1'b0;
        m_int_en = 1'b1;
        #1;
        check("rst_async", obs, ev(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(I_POP, run_exp(8'h00), "rst_pop_ignored");
        tick(8'h00, run_exp(8'h00), "rst_run");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Guard against a runaway simulation
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
